// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that shares one valid/ready stream among NUM_REQS requesters.
// LOCK_LAST holds the grant until a last beat; OUT_REG=1 adds a 1-cycle output stage with one skid entry.
module stream_rr_arbiter #(
  parameter int  NUM_REQS  = 4,
  parameter int  DATAW     = 32,
  parameter int  LOCK_LAST = 0,
  parameter int  OUT_REG   = 1,
  localparam int SELW      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  input  logic [NUM_REQS-1:0]       last_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic                      last_out,
  output logic [SELW-1:0]           sel_out,
  input  logic                      ready_out
);

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic             last;
    logic [SELW-1:0]  sel;
  } beat_t;

  logic [SELW-1:0] rr_ptr;
  logic            lock_valid;
  logic [SELW-1:0] lock_idx;

  logic [SELW-1:0] grant;
  logic            grant_vld;
  logic [SELW:0]   scan_sum;
  logic [SELW-1:0] next_ptr;
  beat_t           in_beat;
  logic            in_valid;
  logic            stage_ready;
  logic            accept;

  // Offsets are scanned from farthest to nearest so the requester closest to rr_ptr wins.
  always_comb begin
    grant     = lock_idx;
    grant_vld = lock_valid;
    scan_sum  = '0;
    if (!lock_valid) begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        scan_sum = {1'b0, rr_ptr} + (SELW+1)'(k);
        if (scan_sum >= (SELW+1)'(NUM_REQS)) begin
          scan_sum = scan_sum - (SELW+1)'(NUM_REQS);
        end
        if (valid_in[scan_sum[SELW-1:0]]) begin
          grant     = scan_sum[SELW-1:0];
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_beat = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant == SELW'(i)) begin
        in_beat.data = data_in[i*DATAW +: DATAW];
        in_beat.last = last_in[i];
      end
    end
    in_beat.sel = grant;
  end

  always_comb begin
    ready_in = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      ready_in[i] = grant_vld & stage_ready & (grant == SELW'(i));
    end
  end

  assign in_valid = grant_vld & valid_in[grant];
  assign accept   = in_valid & stage_ready;
  assign next_ptr = (grant == SELW'(NUM_REQS - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_idx   <= '0;
    end else if (accept) begin
      if ((LOCK_LAST != 0) && !in_beat.last) begin
        lock_valid <= 1'b1;
        lock_idx   <= grant;
      end else begin
        lock_valid <= 1'b0;
        rr_ptr     <= next_ptr;
      end
    end
  end

  if (OUT_REG != 0) begin : g_reg
    beat_t out_q;
    beat_t skid_q;
    logic  out_vld;
    logic  skid_vld;
    logic  out_free;

    // ready_in depends only on skid occupancy, never on ready_out.
    assign stage_ready = ~skid_vld;
    assign out_free    = ~out_vld | ready_out;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        out_vld  <= 1'b0;
        skid_vld <= 1'b0;
        out_q    <= '0;
        skid_q   <= '0;
      end else if (out_free) begin
        if (skid_vld) begin
          out_q    <= skid_q;
          out_vld  <= 1'b1;
          skid_vld <= 1'b0;
        end else if (accept) begin
          out_q   <= in_beat;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (accept) begin
        skid_q   <= in_beat;
        skid_vld <= 1'b1;
      end
    end

    assign valid_out = out_vld;
    assign data_out  = out_q.data;
    assign last_out  = out_q.last;
    assign sel_out   = out_q.sel;
  end else begin : g_comb
    assign stage_ready = ready_out;
    assign valid_out   = in_valid;
    assign data_out    = in_beat.data;
    assign last_out    = in_beat.last;
    assign sel_out     = in_beat.sel;
  end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one valid/ready output stream between NUM_REQS requesters using fair round-robin arbitration.
- Optional packet locking holds the grant until a multi-beat transfer completes.
- Optional registered output with full-throughput skid storage.
- Sits in front of shared pipeline resources: cache request ports, memory channels, writeback buses.

Parameters:
- NUM_REQS, 4: number of requesters (2..16).
- DATAW, 32: payload width per requester.
- LOCK_LAST, 0: 1 = grant held on a requester until it transfers a beat with last_in=1; 0 = re-arbitrate after every beat.
- OUT_REG, 1: 0 = combinational path from input to output; 1 = registered output, 1-cycle latency, 100% throughput.
- SELW, max(1, clog2(NUM_REQS)): width of the index field (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous reset, active-low (0 = reset asserted).
- valid_in  in  NUM_REQS  per-requester valid.
- data_in  in  NUM_REQS*DATAW  requester i payload at bits [i*DATAW +: DATAW].
- last_in  in  NUM_REQS  per-requester end-of-packet flag; ignored when LOCK_LAST=0.
- ready_in  out  NUM_REQS  per-requester ready; at most one bit high per cycle.
- valid_out  out  1  output valid.
- data_out  out  DATAW  granted payload.
- last_out  out  1  last flag of the granted beat.
- sel_out  out  SELW  index of the requester that sourced the current output beat.
- ready_out  in  1  downstream ready.

Behaviour:
- State: rr_ptr (SELW bits), lock_valid, lock_idx; when OUT_REG=1, also the output register and one skid entry.
- Reset (reset=0, asynchronous):
  - rr_ptr=0, lock_valid=0, valid_out=0, all skid/out valid bits 0.
  - data_out, last_out and sel_out registers = 0.
  - Any in-flight beat is discarded.
  - Release is synchronous to clk; the first grant can occur in the first cycle after release.
- Grant selection (combinational):
  - If lock_valid, grant = lock_idx whether or not that requester is valid; other requesters stall.
  - Else grant = first i with valid_in[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQS.
  - No valid input means no grant and no ready_in asserted.
- Accept condition: accept = valid_in[grant] & ready_in[grant]. ready_in[i] = (i==grant) & stage_ready.
- Pointer update on accept:
  - LOCK_LAST=0: rr_ptr <= (grant+1) mod NUM_REQS.
  - LOCK_LAST=1 with last_in[grant]=0: lock_valid <= 1, lock_idx <= grant, rr_ptr unchanged.
  - LOCK_LAST=1 with last_in[grant]=1: lock_valid <= 0, rr_ptr <= (grant+1) mod NUM_REQS.
  - Wrap: grant = NUM_REQS-1 sets rr_ptr to 0.
  - No accept means no state change.
- OUT_REG=0:
  - stage_ready = ready_out.
  - valid_out = valid_in[grant] when a grant exists, else 0.
  - data_out, last_out and sel_out driven combinationally from grant.
- OUT_REG=1:
  - Output register plus one skid entry.
  - stage_ready = ~skid_valid (registered, no combinational path from ready_out to ready_in).
  - Accepted beat goes to the output register if it is empty or draining this cycle, otherwise to the skid entry.
  - When the output drains and the skid entry is full, the skid entry moves into the output register.
  - Latency 1 cycle; sustains 1 beat/cycle under continuous ready_out=1.
  - Output fields must stay stable while valid_out=1 and ready_out=0.
- Simultaneous events:
  - Output drain and new accept in the same cycle: both take effect, no bubble and no loss.
  - New requester asserting valid while another is locked is not granted until the lock releases.
- Ordering: beats from a single requester leave in acceptance order. Packets from different requesters never interleave when LOCK_LAST=1.
- Deasserting valid_in of a locked requester mid-packet is legal; the lock persists.

Test Plan:
- Fairness: NUM_REQS=4, LOCK_LAST=0, all valid_in=4'b1111 continuous, ready_out=1 -> sel_out sequence 0,1,2,3,0,1,... and valid_out high every cycle after 1-cycle latency.
- Sparse/wrap: rr_ptr=3, only valid_in[1] set -> requester 1 granted, next rr_ptr=2. Then valid_in[3] and valid_in[0] both set -> grant 3, then 0.
- Backpressure: OUT_REG=1, stream 8 beats from requester 2 with ready_out toggling 1,0,0,1,... -> all 8 data values delivered in order, none duplicated, output stable during stalls, ready_in[2]=0 only while skid is full.
- Lock: LOCK_LAST=1, requester 0 sends 3 beats (last on beat 3) while requester 1 is valid throughout -> output shows 0,0,0 then 1, with no interleave.
- Reset mid-operation: assert reset low with valid_out=1 and skid full -> valid_out=0 immediately (asynchronous). After release, rr_ptr=0 and the first grant goes to the lowest valid index.
- Idle: no valid_in for 10 cycles -> valid_out=0, ready_in=0, rr_ptr unchanged.
